// File: rtl/cart_mem_responder_pkg.sv
// Shared types and defaults for the cartridge memory responder.
// The state enum and default parameter values live here so the top and any other users agree on them.
package cart_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        REQ,
        HOLD
    } cart_mem_state_t;

    localparam logic [24:0] CART_SRAM_BASE   = 25'h1F00000;
    localparam int          CART_MEM_TIMEOUT = 63;

endpackage

// File: rtl/cart_mem_responder_cache1.sv
// Single-entry read cache: one tag/data pair with a valid bit.
// Invalidation always wins over a fill or a write-update arriving in the same cycle.
module cart_mem_cache1 #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [7:0]        rd_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [7:0]        fill_data,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [7:0]        upd_data,
    input  logic              inval
);

    logic              valid_reg;
    logic [ADDR_W-1:0] tag_reg;
    logic [7:0]        data_reg;

    assign hit     = valid_reg && (tag_reg == lookup_addr);
    assign rd_data = data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= 8'h00;
        end else if (inval) begin
            valid_reg <= 1'b0;
        end else if (fill_en) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_addr;
            data_reg  <= fill_data;
        end else if (upd_en && valid_reg && (tag_reg == upd_addr)) begin
            data_reg  <= upd_data;
        end
    end

endmodule

// File: rtl/cart_mem_responder.sv
// Turns Z80 cartridge accesses into req/ack transactions on the ROM/SRAM memory port,
// stalling the CPU via WAIT until data returns; reads are served from a 1-entry cache when possible.
module cart_mem_responder
    import cart_mem_responder_pkg::*;
#(
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] SRAM_BASE = CART_SRAM_BASE,
    parameter int                SRAM_AW   = 17,
    parameter int                TIMEOUT   = CART_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic              mreq,
    input  logic              en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              sram_oe,
    input  logic              sram_we,
    input  logic [7:0]        d_from_cpu,
    output logic [7:0]        d_to_cpu,
    output logic              data_oe,
    output logic              wait_n,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic              ram_ack,
    input  logic [7:0]        ram_dout,
    input  logic              cache_inval
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    cart_mem_state_t   state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [7:0]        d_to_cpu_reg, d_to_cpu_next;
    logic              data_oe_reg, data_oe_next;
    logic              wait_n_reg, wait_n_next;
    logic              ram_req_reg, ram_req_next;
    logic              ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
    logic [7:0]        ram_din_reg, ram_din_next;
    logic              is_read_reg, is_read_next;
    logic              act_prev_reg;

    logic              act;
    logic              start;
    logic [ADDR_W-1:0] ea;
    logic              cache_hit;
    logic [7:0]        cache_data;
    logic              fill_en;
    logic              upd_en;
    logic              tmo_inval;

    assign act   = (rd | wr) & mreq & en;
    assign start = act & ~act_prev_reg;

    // SRAM accesses are relocated into the backup-SRAM window; ROM addresses pass through untouched
    assign ea = (sram_oe | sram_we)
              ? SRAM_BASE + {{(ADDR_W-SRAM_AW){1'b0}}, mem_addr[SRAM_AW-1:0]}
              : mem_addr;

    cart_mem_cache1 #(
        .ADDR_W (ADDR_W)
    ) u_cache (
        .clk         (clk),
        .reset       (reset),
        .lookup_addr (ea),
        .hit         (cache_hit),
        .rd_data     (cache_data),
        .fill_en     (fill_en),
        .fill_addr   (ram_addr_reg),
        .fill_data   (ram_dout),
        .upd_en      (upd_en),
        .upd_addr    (ram_addr_reg),
        .upd_data    (ram_din_reg),
        .inval       (cache_inval | tmo_inval)
    );

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        d_to_cpu_next = d_to_cpu_reg;
        data_oe_next  = data_oe_reg;
        wait_n_next   = wait_n_reg;
        ram_req_next  = ram_req_reg;
        ram_we_next   = ram_we_reg;
        ram_addr_next = ram_addr_reg;
        ram_din_next  = ram_din_reg;
        is_read_next  = is_read_reg;
        fill_en       = 1'b0;
        upd_en        = 1'b0;
        tmo_inval     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (start && !wr && cache_hit) begin
                    state_next    = HIT;
                    data_oe_next  = 1'b1;
                    d_to_cpu_next = cache_data;
                end else if (start && (!wr || sram_we)) begin
                    // read miss or SRAM write; ROM writes fall through and are dropped
                    state_next    = REQ;
                    wait_n_next   = 1'b0;
                    ram_req_next  = 1'b1;
                    ram_we_next   = wr;
                    ram_addr_next = ea;
                    ram_din_next  = d_from_cpu;
                    is_read_next  = !wr;
                    cnt_next      = '0;
                end
            end

            REQ: begin
                if (ram_ack) begin
                    state_next   = HOLD;
                    ram_req_next = 1'b0;
                    wait_n_next  = 1'b1;
                    if (is_read_reg) begin
                        d_to_cpu_next = ram_dout;
                        data_oe_next  = 1'b1;
                        fill_en       = 1'b1;
                    end else begin
                        upd_en = 1'b1;
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    // forced completion: the CPU sees open-bus data, the cache keeps nothing stale
                    state_next    = HOLD;
                    ram_req_next  = 1'b0;
                    wait_n_next   = 1'b1;
                    d_to_cpu_next = 8'hFF;
                    data_oe_next  = rd;
                    tmo_inval     = !is_read_reg;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            HIT, HOLD: begin
                if (!act) begin
                    state_next    = IDLE;
                    data_oe_next  = 1'b0;
                    d_to_cpu_next = 8'hFF;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            d_to_cpu_reg <= 8'hFF;
            data_oe_reg  <= 1'b0;
            wait_n_reg   <= 1'b1;
            ram_req_reg  <= 1'b0;
            ram_we_reg   <= 1'b0;
            ram_addr_reg <= '0;
            ram_din_reg  <= 8'h00;
            is_read_reg  <= 1'b0;
            act_prev_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            d_to_cpu_reg <= d_to_cpu_next;
            data_oe_reg  <= data_oe_next;
            wait_n_reg   <= wait_n_next;
            ram_req_reg  <= ram_req_next;
            ram_we_reg   <= ram_we_next;
            ram_addr_reg <= ram_addr_next;
            ram_din_reg  <= ram_din_next;
            is_read_reg  <= is_read_next;
            act_prev_reg <= act;
        end
    end

    assign d_to_cpu = d_to_cpu_reg;
    assign data_oe  = data_oe_reg;
    assign wait_n   = wait_n_reg;
    assign ram_req  = ram_req_reg;
    assign ram_we   = ram_we_reg;
    assign ram_addr = ram_addr_reg;
    assign ram_din  = ram_din_reg;

endmodule

// File: tb/tb_cart_mem_responder.sv
// Scoreboard bench for cart_mem_responder: directed corner cases followed by random accesses,
// checked against a behavioural model of the cache, the memory and the WAIT timing.
module tb_cart_mem_responder;

    localparam int TB_TIMEOUT = 63;

    typedef struct packed {
        logic [24:0] addr;
        logic        we;
        logic [7:0]  din;
    } req_t;

    logic        clk;
    logic        reset;
    logic        rd, wr, mreq, en;
    logic [24:0] mem_addr;
    logic        sram_oe, sram_we;
    logic [7:0]  d_from_cpu;
    logic [7:0]  d_to_cpu;
    logic        data_oe, wait_n;
    logic        ram_req, ram_we;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_ack;
    logic [7:0]  ram_dout;
    logic        cache_inval;
    logic        inval_d, inval_r;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    req_t       exp_req_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] mem[logic [24:0]];

    // model cache
    logic        cvalid = 1'b0;
    logic [24:0] ctag   = '0;
    logic [7:0]  cdata  = '0;

    // responder control: 0 ack after lat, 1 withhold then late ack, 2 withhold silent, 3 ack with cache_inval
    int resp_mode = 0;
    int resp_lat  = 1;

    assign cache_inval = inval_d | inval_r;

    cart_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .rd          (rd),
        .wr          (wr),
        .mreq        (mreq),
        .en          (en),
        .mem_addr    (mem_addr),
        .sram_oe     (sram_oe),
        .sram_we     (sram_we),
        .d_from_cpu  (d_from_cpu),
        .d_to_cpu    (d_to_cpu),
        .data_oe     (data_oe),
        .wait_n      (wait_n),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_ack     (ram_ack),
        .ram_dout    (ram_dout),
        .cache_inval (cache_inval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [24:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // external memory: sole writer of mem, ram_ack, ram_dout and inval_r
    initial begin : responder
        ram_ack  = 1'b0;
        ram_dout = 8'h00;
        inval_r  = 1'b0;
        mem[25'h0004000] = 8'h3C;
        forever begin
            @(posedge clk); #1;
            if (ram_req && !reset) begin
                if (resp_mode == 0 || resp_mode == 3) begin
                    repeat (resp_lat - 1) begin @(posedge clk); #1; end
                    ram_ack  = 1'b1;
                    ram_dout = ram_we ? 8'h00 : mem_rd(ram_addr);
                    if (ram_we) mem[ram_addr] = ram_din;
                    inval_r  = (resp_mode == 3);
                    @(posedge clk); #1;
                    ram_ack  = 1'b0;
                    inval_r  = 1'b0;
                    ram_dout = 8'($urandom);
                end else begin
                    for (int i = 0; i < 200 && ram_req; i++) begin @(posedge clk); #1; end
                    if (resp_mode == 1) begin
                        ram_ack  = 1'b1;
                        ram_dout = 8'h77;
                        @(posedge clk); #1;
                        ram_ack  = 1'b0;
                    end
                end
            end
        end
    end

    // monitor: pops expectations whenever a request or read data appears
    initial begin : monitor
        logic req_prev, oe_prev;
        req_t cur;
        logic [7:0] ed;
        req_prev = 1'b0;
        oe_prev  = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (ram_req === 1'b1 && !req_prev) begin
                check("req_expected", 64'(exp_req_q.size() > 0), 64'd1);
                if (exp_req_q.size() > 0) begin
                    cur = exp_req_q.pop_front();
                    check("ram_addr", 64'(ram_addr), 64'(cur.addr));
                    check("ram_we", 64'(ram_we), 64'(cur.we));
                    check("ram_din", 64'(ram_din), 64'(cur.din));
                end
            end else if (ram_req === 1'b1) begin
                check("req_stable", 64'({ram_addr, ram_we, ram_din}), 64'({cur.addr, cur.we, cur.din}));
            end
            if (data_oe === 1'b1 && !oe_prev) begin
                check("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
                if (exp_rd_q.size() > 0) begin
                    ed = exp_rd_q.pop_front();
                    check("d_to_cpu", 64'(d_to_cpu), 64'(ed));
                end
            end
            req_prev = (ram_req === 1'b1);
            oe_prev  = (data_oe === 1'b1);
        end
    end

    task automatic drop_bus();
        rd = 1'b0; wr = 1'b0; mreq = 1'b0; en = 1'b0;
        sram_oe = 1'b0; sram_we = 1'b0;
    endtask

    task automatic inval_pulse();
        @(posedge clk); #1;
        inval_d = 1'b1;
        @(posedge clk); #1;
        inval_d = 1'b0;
        cvalid  = 1'b0;
    endtask

    task automatic access(input bit is_wr, input bit sram, input logic [24:0] addr,
                          input logic [7:0] din, input int mode, input int lat, input int drop_after);
        logic [24:0] ea;
        logic [7:0]  data;
        int          exp_wait;
        int          n;
        ea        = sram ? 25'(32'h1F00000 + (32'(addr) % (32'd1 << 17))) : addr;
        resp_mode = mode;
        resp_lat  = lat;
        exp_wait  = 0;
        if (!is_wr) begin
            if (cvalid && ctag == ea) begin
                exp_rd_q.push_back(cdata);
            end else begin
                exp_req_q.push_back('{addr: ea, we: 1'b0, din: din});
                if (mode == 1 || mode == 2) begin
                    exp_rd_q.push_back(8'hFF);
                    exp_wait = TB_TIMEOUT + 1;
                end else begin
                    data = mem_rd(ea);
                    exp_rd_q.push_back(data);
                    exp_wait = lat;
                    if (mode != 3) begin
                        cvalid = 1'b1; ctag = ea; cdata = data;
                    end
                end
            end
        end else if (sram) begin
            exp_req_q.push_back('{addr: ea, we: 1'b1, din: din});
            if (mode == 1 || mode == 2) begin
                exp_wait = TB_TIMEOUT + 1;
                cvalid   = 1'b0;
            end else begin
                exp_wait = lat;
                if (mode == 3) cvalid = 1'b0;
                else if (cvalid && ctag == ea) cdata = din;
            end
        end

        @(posedge clk); #1;
        mem_addr = addr; d_from_cpu = din;
        sram_oe = sram && !is_wr; sram_we = sram && is_wr;
        rd = !is_wr; wr = is_wr; mreq = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (wait_n !== 1'b1 && n < 300) begin
            n++;
            if (drop_after != 0 && n == drop_after) begin
                rd = 1'b0; wr = 1'b0; mreq = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("wait_cycles", 64'(n), 64'(exp_wait));
        drop_bus();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle_data_oe", 64'(data_oe), 64'd0);
        check("idle_d_to_cpu", 64'(d_to_cpu), 64'hFF);
        check("idle_ram_req", 64'(ram_req), 64'd0);
        txn++;
        $display("txn %0d: %s%s addr=%h ea=%h din=%h mode=%0d lat=%0d wait=%0d",
                 txn, sram ? "sram_" : "rom_", is_wr ? "wr" : "rd", addr, ea, din, mode, lat, n);
    endtask

    task automatic reset_mid_req(input logic [24:0] addr);
        resp_mode = 2;
        exp_req_q.push_back('{addr: addr, we: 1'b0, din: 8'h00});
        @(posedge clk); #1;
        mem_addr = addr; d_from_cpu = 8'h00;
        rd = 1'b1; mreq = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        check("rst_pre_wait_n", 64'(wait_n), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        drop_bus();
        @(posedge clk); #1;
        check("rst_ram_req", 64'(ram_req), 64'd0);
        check("rst_wait_n", 64'(wait_n), 64'd1);
        check("rst_d_to_cpu", 64'(d_to_cpu), 64'hFF);
        reset  = 1'b0;
        cvalid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        txn++;
        $display("txn %0d: reset during request addr=%h", txn, addr);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [24:0] rom_pool[4];
        logic [24:0] sram_off[4];
        logic [24:0] a;
        int          kind, mode;
        rom_pool = '{25'h0004000, 25'h0004001, 25'h0008000, 25'h000A000};
        sram_off = '{25'h0000000, 25'h0000001, 25'h0000123, 25'h001FFFF};
        reset = 1'b1; inval_d = 1'b0;
        rd = 1'b0; wr = 1'b0; mreq = 1'b0; en = 1'b0;
        mem_addr = '0; sram_oe = 1'b0; sram_we = 1'b0; d_from_cpu = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_d_to_cpu", 64'(d_to_cpu), 64'hFF);
        check("reset_data_oe", 64'(data_oe), 64'd0);
        check("reset_wait_n", 64'(wait_n), 64'd1);
        check("reset_ram_req", 64'(ram_req), 64'd0);
        check("reset_ram_we", 64'(ram_we), 64'd0);
        check("reset_ram_addr", 64'(ram_addr), 64'd0);
        check("reset_ram_din", 64'(ram_din), 64'd0);
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        access(0, 0, 25'h0004000, 8'h00, 0, 5, 0);   // cold miss
        access(0, 0, 25'h0004000, 8'h00, 0, 1, 0);   // hit
        access(1, 1, 25'h0000123, 8'hA5, 0, 3, 0);   // SRAM write
        access(0, 1, 25'h0000123, 8'h00, 0, 2, 0);   // SRAM read miss
        access(1, 0, 25'h0004000, 8'h99, 0, 2, 0);   // ROM write ignored
        access(1, 1, 25'h0000123, 8'h5C, 0, 2, 0);   // write updates cached entry
        access(0, 1, 25'h0000123, 8'h00, 0, 2, 0);   // hit with updated data
        inval_pulse();
        access(0, 0, 25'h0004000, 8'h00, 0, 4, 0);   // miss after inval
        access(0, 0, 25'h0008000, 8'h00, 1, 1, 0);   // read timeout + late ack
        access(0, 0, 25'h0008000, 8'h00, 0, 2, 0);   // still a miss
        access(0, 0, 25'h000C000, 8'h00, 3, 3, 0);   // inval same cycle as ack
        access(0, 0, 25'h000C000, 8'h00, 0, 1, 0);   // not cached
        access(0, 0, 25'h0002222, 8'h00, 0, 6, 2);   // strobes drop mid-request
        access(0, 1, 25'h0000456, 8'h00, 0, 2, 0);
        access(1, 1, 25'h0000456, 8'hE1, 1, 1, 0);   // write timeout invalidates
        access(0, 1, 25'h0000456, 8'h00, 0, 2, 0);
        access(0, 0, 25'h0004000, 8'h00, 0, 2, 0);
        reset_mid_req(25'h0006000);
        access(0, 0, 25'h0004000, 8'h00, 0, 3, 0);   // cache lost by reset

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            mode = ($urandom_range(0, 15) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 3 : 0);
            if ($urandom_range(0, 7) == 0) inval_pulse();
            if (kind == 1 || kind == 2)
                a = 25'((32'($urandom) & 32'h01FE0000) | 32'(sram_off[$urandom_range(0, 3)]));
            else
                a = rom_pool[$urandom_range(0, 3)];
            access(kind >= 2, kind == 1 || kind == 2, a, 8'($urandom), mode, int'($urandom_range(1, 8)), 0);
        end

        repeat (4) begin @(posedge clk); #1; end
        check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
